// File: rtl/mult_div_unit_pkg.sv
// Shared MD constants: op encodings and default latencies. The controller decode
// and the hazard unit import the same definitions.
package mult_div_unit_pkg;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6
    } md_op_t;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    // True for the ops that occupy the unit for several cycles.
    function automatic logic is_calc_op(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/mult_div_unit_md_calc.sv
// Combinational 2*WIDTH-bit multiply/divide datapath. Result layout is {hi, lo};
// for divides that is {remainder, quotient}.
module md_calc
    import mult_div_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] result,
    output logic               div_by_zero
);

    logic                      overflow;
    logic [WIDTH-1:0]          b_safe_u;
    logic [WIDTH-1:0]          b_safe_s;
    logic signed [2*WIDTH-1:0] prod_s;
    logic [2*WIDTH-1:0]        prod_u;
    logic signed [WIDTH-1:0]   quot_s;
    logic signed [WIDTH-1:0]   rem_s;
    logic [WIDTH-1:0]          quot_u;
    logic [WIDTH-1:0]          rem_u;

    assign div_by_zero = (b == '0);
    assign overflow    = (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);

    // Most-negative / -1 is steered to a divide by 1, which yields exactly the
    // required quotient (the dividend) and a zero remainder.
    assign b_safe_u = div_by_zero ? WIDTH'(1) : b;
    assign b_safe_s = (div_by_zero || overflow) ? WIDTH'(1) : b;

    assign prod_s = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
    assign prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    assign quot_s = $signed(a) / $signed(b_safe_s);
    assign rem_s  = $signed(a) % $signed(b_safe_s);
    assign quot_u = a / b_safe_u;
    assign rem_u  = a % b_safe_u;

    // NOTE: default assignment first so no path through the case infers a latch.
    always_comb begin
        result = '0;
        case (op)
            MD_MULT:  result = prod_s;
            MD_MULTU: result = prod_u;
            MD_DIV:   result = {rem_s, quot_s};
            MD_DIVU:  result = {rem_u, quot_u};
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/mult_div_unit.sv
// E-stage multiply/divide unit: owns HI/LO, models fixed multi-cycle latency with a
// down-counter, and raises the D-stage stall for MD-using instructions.
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       md_op_e,
    input  logic [WIDTH-1:0] rs_e,
    input  logic [WIDTH-1:0] rt_e,
    input  logic             md_use_d,
    output logic             busy,
    output logic             start,
    output logic             stall_req,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(DIV_CYCLES + 1);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t             state;
    logic [CNT_W-1:0]   count;
    logic [2*WIDTH-1:0] shadow;
    logic               shadow_keep;
    logic [2*WIDTH-1:0] calc_result;
    logic               calc_dz;
    logic               is_div;

    md_calc #(.WIDTH(WIDTH)) u_calc (
        .op          (md_op_e),
        .a           (rs_e),
        .b           (rt_e),
        .result      (calc_result),
        .div_by_zero (calc_dz)
    );

    assign is_div    = (md_op_e == MD_DIV) || (md_op_e == MD_DIVU);
    assign start     = !busy && is_calc_op(md_op_e);
    assign stall_req = md_use_d & (start | busy);

    // NOTE: non-blocking assignments for all state so every register samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            busy        <= 1'b0;
            count       <= '0;
            shadow      <= '0;
            shadow_keep <= 1'b0;
            hi          <= '0;
            lo          <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        shadow      <= calc_result;
                        shadow_keep <= is_div && calc_dz;
                        count       <= is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                        state       <= S_RUN;
                        busy        <= 1'b1;
                    end else if (md_op_e == MD_MTHI) begin
                        hi <= rs_e;
                    end else if (md_op_e == MD_MTLO) begin
                        lo <= rs_e;
                    end
                end
                S_RUN: begin
                    // Ops arriving here are dropped; the hazard unit keeps them in D.
                    count <= count - 1'b1;
                    if (count == CNT_W'(1)) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        if (!shadow_keep) begin
                            hi <= shadow[2*WIDTH-1:WIDTH];
                            lo <= shadow[WIDTH-1:0];
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed vector table, hand-written
// multi-cycle sequences, and random ops against a plain-arithmetic model.
module tb_mult_div_unit;
    import mult_div_unit_pkg::*;

    logic        clk;
    logic        reset;
    logic [2:0]  md_op_e;
    logic [31:0] rs_e;
    logic [31:0] rt_e;
    logic        md_use_d;
    logic        busy;
    logic        start;
    logic        stall_req;
    logic [31:0] hi;
    logic [31:0] lo;

    int errors = 0;
    int checks = 0;

    mult_div_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk       (clk),
        .reset     (reset),
        .md_op_e   (md_op_e),
        .rs_e      (rs_e),
        .rt_e      (rt_e),
        .md_use_d  (md_use_d),
        .busy      (busy),
        .start     (start),
        .stall_req (stall_req),
        .hi        (hi),
        .lo        (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference behaviour written from the architectural definition of each op.
    function automatic void ref_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                   inout logic [31:0] h, inout logic [31:0] l, output int cyc);
        longint      sa, sb, sq, sr;
        logic [63:0] ua, ub, up, uq, ur;
        logic [63:0] sp;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        cyc = 0;
        case (op)
            3'd1: begin sp = 64'(sa * sb); h = sp[63:32]; l = sp[31:0]; cyc = 5; end
            3'd2: begin up = ua * ub; h = up[63:32]; l = up[31:0]; cyc = 5; end
            3'd3: begin
                cyc = 10;
                if (b != 0) begin
                    sq = sa / sb; sr = sa % sb;
                    l = sq[31:0]; h = sr[31:0];
                end
            end
            3'd4: begin
                cyc = 10;
                if (b != 0) begin
                    uq = ua / ub; ur = ua % ub;
                    l = uq[31:0]; h = ur[31:0];
                end
            end
            3'd5: h = a;
            3'd6: l = a;
            default: ;
        endcase
    endfunction

    // Issue one op from idle, check start, and count busy cycles (bounded).
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input string name, output int cycles);
        logic exp_start;
        exp_start = (op >= 3'd1) && (op <= 3'd4);
        @(negedge clk);
        md_op_e = op; rs_e = a; rt_e = b;
        #1;
        check({name, ".start"}, 64'(start), 64'(exp_start));
        @(posedge clk);
        #1;
        md_op_e = MD_NONE;
        cycles = 0;
        while (busy && cycles < 40) begin
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          exp_cyc;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int          cyc;
        int          n;
        logic [31:0] mh, ml;
        logic [2:0]  rop;
        logic [31:0] ra, rb;
        int          ecyc;

        vecs[0] = '{"mult_neg",   MD_MULT,  32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFFA, 5};
        vecs[1] = '{"multu",      MD_MULTU, 32'hFFFF_FFFE, 32'd3,         32'h0000_0002, 32'hFFFF_FFFA, 5};
        vecs[2] = '{"div_neg",    MD_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
        vecs[3] = '{"divu",       MD_DIVU,  32'd7,         32'd2,         32'd1,         32'd3,         10};
        vecs[4] = '{"div_ovf",    MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000, 10};
        vecs[5] = '{"mthi",       MD_MTHI,  32'h0000_1234, 32'd0,         32'h0000_1234, 32'h8000_0000, 0};
        vecs[6] = '{"mtlo",       MD_MTLO,  32'h0000_5678, 32'd0,         32'h0000_1234, 32'h0000_5678, 0};
        vecs[7] = '{"divu_zero",  MD_DIVU,  32'hDEAD_BEEF, 32'd0,         32'h0000_1234, 32'h0000_5678, 10};

        reset = 1'b1; md_op_e = MD_NONE; rs_e = '0; rt_e = '0; md_use_d = 1'b0;
        repeat (2) @(negedge clk);
        check("reset.busy", 64'(busy), 64'd0);
        check("reset.hi",   64'(hi),   64'd0);
        check("reset.lo",   64'(lo),   64'd0);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            issue(vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].name, cyc);
            check({vecs[i].name, ".cycles"}, 64'(cyc),  64'(vecs[i].exp_cyc));
            check({vecs[i].name, ".hi"},     64'(hi),   64'(vecs[i].exp_hi));
            check({vecs[i].name, ".lo"},     64'(lo),   64'(vecs[i].exp_lo));
        end

        // Stall request with and without an MD user in D.
        for (int pass = 0; pass < 2; pass++) begin
            @(negedge clk);
            md_use_d = (pass == 0);
            md_op_e = MD_MULT; rs_e = 32'd2; rt_e = 32'd2;
            n = 0;
            for (int i = 0; i < 10; i++) begin
                #1;
                if (stall_req) n++;
                @(posedge clk);
                #1;
                md_op_e = MD_NONE;
                @(negedge clk);
            end
            #1;
            check(pass == 0 ? "stall.count_use" : "stall.count_nouse", 64'(n), pass == 0 ? 64'd6 : 64'd0);
            check("stall.after", 64'(stall_req), 64'd0);
            md_use_d = 1'b0;
        end

        // Back-to-back: second MULT in the first idle cycle.
        issue(MD_MULT, 32'd3, 32'd5, "b2b_first", cyc);
        check("b2b_first.cycles", 64'(cyc), 64'd5);
        check("b2b_first.lo",     64'(lo),  64'd15);
        @(negedge clk);
        md_op_e = MD_MULT; rs_e = 32'hFFFF_FFFF; rt_e = 32'hFFFF_FFFF;
        #1;
        check("b2b_second.start", 64'(start), 64'd1);
        @(posedge clk);
        #1;
        md_op_e = MD_NONE;
        for (int i = 0; i < 5; i++) begin
            check("b2b_hold.busy", 64'(busy), 64'd1);
            check("b2b_hold.hilo", {hi, lo}, {32'd0, 32'd15});
            @(posedge clk);
            #1;
        end
        check("b2b_second.busy", 64'(busy), 64'd0);
        check("b2b_second.hilo", {hi, lo}, {32'd0, 32'd1});

        // Reset during the third busy cycle of a DIV.
        issue(MD_MTHI, 32'hAAAA_0000, 32'd0, "pre_rst_mthi", cyc);
        @(negedge clk);
        md_op_e = MD_DIV; rs_e = 32'd100; rt_e = 32'd7;
        @(posedge clk);
        #1;
        md_op_e = MD_NONE;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("midrst.busy", 64'(busy), 64'd0);
        check("midrst.hi",   64'(hi),   64'd0);
        check("midrst.lo",   64'(lo),   64'd0);
        @(negedge clk);
        reset = 1'b0;
        issue(MD_MULT, 32'd6, 32'd7, "post_rst_mult", cyc);
        check("post_rst.cycles", 64'(cyc), 64'd5);
        check("post_rst.hilo",   {hi, lo}, {32'd0, 32'd42});

        // Random ops against the model, starting from a fresh reset.
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        mh = '0; ml = '0;
        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = $urandom;
            if ($urandom_range(0, 3) == 0) ra = 32'($urandom_range(0, 9)) - 32'd5;
            if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(0, 4)) - 32'd2;
            ref_md(rop, ra, rb, mh, ml, ecyc);
            issue(rop, ra, rb, "rand", cyc);
            check("rand.cycles", 64'(cyc), 64'(ecyc));
            check("rand.hilo",   {hi, lo}, {mh, ml});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Multi-cycle multiply/divide unit with HI/LO registers for the pipelined MIPS core, sitting in the E stage beside the ALU. It accepts one MD operation per issue, models fixed multi-cycle latency with a busy counter, and produces the stall request the hazard logic uses to hold any later MD-using instruction in D. It sequences the shared HI/LO resource; no other block writes HI/LO.

## Interface
- `WIDTH`, 32: operand and HI/LO width.
- `MULT_CYCLES`, 5: busy cycles for MULT/MULTU.
- `DIV_CYCLES`, 10: busy cycles for DIV/DIVU.

- `clk` in 1: single clock, all state on rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `md_op_e` in 3: E-stage MD op; encodings in shared constants (NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6, others treated as NONE).
- `rs_e` in WIDTH: forwarded rs value (dividend/multiplicand/MT source).
- `rt_e` in WIDTH: forwarded rt value (divisor/multiplier).
- `md_use_d` in 1: D-stage instruction is any of MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO.
- `busy` out 1: operation in progress; registered.
- `start` out 1: combinational; E-stage op is MULT/MULTU/DIV/DIVU and unit accepts it.
- `stall_req` out 1: combinational; `md_use_d & (start | busy)`.
- `hi` out WIDTH: HI register.
- `lo` out WIDTH: LO register.

## Operation
- States: IDLE (`busy`=0), RUN (`busy`=1). Counter width ceil(log2(DIV_CYCLES+1)).
- IDLE, start op sampled: compute 64-bit result from `rs_e`/`rt_e` into shadow regs, load counter with MULT_CYCLES or DIV_CYCLES, go RUN.
- RUN: counter decrements each edge; on the edge where it goes 1→0, commit shadow to `hi`/`lo`, go IDLE.
- MULT: signed 64-bit product, `hi`=[63:32], `lo`=[31:0]. MULTU: unsigned.
- DIV: signed; `lo`=quotient truncated toward zero, `hi`=remainder with dividend's sign. DIVU: unsigned.
- DIV of 0x8000_0000 by 0xFFFF_FFFF: `lo`=0x8000_0000, `hi`=0.
- Divisor 0 (DIV/DIVU): full busy timing still runs; `hi`/`lo` unchanged at commit.
- MTHI/MTLO in IDLE: `hi`/`lo` ← `rs_e` on that edge; no busy.
- Any op presented while `busy`=1: ignored (no start, no MT write). Hazard logic prevents this; bench flags it.
- `reset` asserted any time (incl. mid-RUN): immediately `busy`=0, counter=0, `hi`=`lo`=0, shadow=0; in-flight result discarded.

## Timing
- Reset values: `busy`=0, `hi`=0, `lo`=0; `start`/`stall_req` follow inputs.
- Start on edge E0 → `busy`=1 for exactly N cycles after E0 (N = MULT_CYCLES/DIV_CYCLES); `busy` falls and `hi`/`lo` update at edge E0+N; MFHI/MFLO in E at cycle after E0+N reads new value.
- `stall_req` high in the start cycle and every busy cycle whenever `md_use_d`=1; low the cycle `busy` is 0 and no start.
- Back-to-back: new start accepted in the first cycle with `busy`=0.
- MTHI/MTLO: value visible on `hi`/`lo` one edge after issue.

## Structure
- Shared constants file: MD op encodings, default cycle counts; also used by controller decode and hazard unit.
- Sub-module `md_calc`: purely combinational 64-bit mult/div result incl. signed/unsigned, overflow and div-by-zero flag; `mult_div_unit` holds FSM, counter, shadow, HI/LO.

## Test plan
- MULT rs=0xFFFF_FFFE (−2), rt=3 → `busy` 5 cycles, then `hi`=0xFFFF_FFFF, `lo`=0xFFFF_FFFA; MULTU same operands → `hi`=0x2, `lo`=0xFFFF_FFFA.
- DIV rs=−7, rt=2 → `busy` 10 cycles, `lo`=0xFFFF_FFFD, `hi`=0xFFFF_FFFF; DIVU 7/2 → `lo`=3, `hi`=1.
- DIV 0x8000_0000 / 0xFFFF_FFFF → `lo`=0x8000_0000, `hi`=0; DIVU x/0 after MTHI 0x1234, MTLO 0x5678 → `busy` 10 cycles, `hi`=0x1234, `lo`=0x5678 kept.
- MULT issued with `md_use_d`=1 throughout → `stall_req`=1 on start cycle plus 5 busy cycles (6 total), 0 after; `md_use_d`=0 → `stall_req` always 0.
- `reset` pulse at busy cycle 3 of DIV → `busy`, `hi`, `lo` = 0 immediately (before next edge); MULT issued right after release completes normally.
- MULT then MULT in first idle cycle after `busy` falls → second accepted, `hi`/`lo` show first result for 5 cycles, then second.
